// File: rtl/regfile_wr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// regfile_wr_arbiter_pkg
// Shared definitions for the register-file write arbiter:
//   REG_W    - register index width
//   DATA_W   - register data width
//   ZERO_REG - default register index whose writes are discarded
//   state_t  - write-stage FSM state (IDLE, WRITE, HOLD)
// ----------------------------------------------------------------------------
package regfile_wr_arbiter_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter.
//   clk, rst_n - clock, asynchronous active-low reset
//   valid[1:0] - request lines (bit 0 = requester 0)
//   update     - strobe: the currently granted request was accepted
//   grant[1:0] - one-hot grant (combinational), zero when nothing is valid
// After reset requester 1 is treated as the last winner, so requester 0 wins
// the first contention.
// ----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       update,
    output logic [1:0] grant
);

    logic lastGrant;

    always_comb begin
        grant = '0;
        if (valid == 2'b11) begin
            grant = lastGrant ? 2'b01 : 2'b10;
        end else if (valid[0]) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastGrant <= 1'b1;
        end else if (update) begin
            lastGrant <= grant[1];
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wr_arbiter
// Arbitrates two write requesters onto a single register-file write port
// through a one-entry write stage, and reports hazards against that stage.
//   clk, rst_n                       - clock, asynchronous active-low reset
//   req0_* (valid, rc, wdata, ready) - requester 0 (pipeline writeback)
//   req1_* (valid, rc, wdata, ready) - requester 1 (load/debug)
//   hold                             - freeze the write stage
//   RegWrite, rc, wdata              - register-file write port
//   q_ra, q_rb                       - hazard query addresses
//   stall                            - a query hits an uncommitted write
//   fwd_a, fwd_b, fwd_data           - forwarding from the staged write
// Writes to ZERO_REG are accepted but never reach the register file.
// ----------------------------------------------------------------------------
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter logic [REG_W-1:0] ZERO_REG = regfile_wr_arbiter_pkg::ZERO_REG
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    input  logic [REG_W-1:0]  req0_rc,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic [REG_W-1:0]  req1_rc,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,

    input  logic              hold,

    output logic              RegWrite,
    output logic [REG_W-1:0]  rc,
    output logic [DATA_W-1:0] wdata,

    input  logic [REG_W-1:0]  q_ra,
    input  logic [REG_W-1:0]  q_rb,
    output logic              stall,
    output logic              fwd_a,
    output logic              fwd_b,
    output logic [DATA_W-1:0] fwd_data
);

    state_t              state;
    logic [REG_W-1:0]    stRc;
    logic [DATA_W-1:0]   stData;

    logic [1:0]          grant;
    logic                canAccept;
    logic                xfer;
    logic [REG_W-1:0]    selRc;
    logic [DATA_W-1:0]   selData;
    logic                stValid;
    logic                stLive;
    logic                hitA;
    logic                hitB;

    rr_arb2 uArb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  ({req1_valid, req0_valid}),
        .update (xfer),
        .grant  (grant)
    );

    // The stage accepts while idle or draining; a drain and a new capture
    // share the same edge, giving one write per cycle.
    assign canAccept  = ((state == IDLE) || (state == WRITE)) && !hold;
    assign req0_ready = grant[0] && req0_valid && canAccept;
    assign req1_ready = grant[1] && req1_valid && canAccept;
    assign xfer       = req0_ready || req1_ready;

    assign selRc   = req1_ready ? req1_rc    : req0_rc;
    assign selData = req1_ready ? req1_wdata : req0_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            stRc   <= '0;
            stData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        stRc   <= selRc;
                        stData <= selData;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    if (hold) begin
                        state <= HOLD;
                    end else if (xfer) begin
                        stRc   <= selRc;
                        stData <= selData;
                        state  <= WRITE;
                    end else begin
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (!hold) begin
                        state <= WRITE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stValid = (state == WRITE) || (state == HOLD);
    assign stLive  = (stRc != ZERO_REG);
    assign hitA    = (q_ra == stRc) && stLive;
    assign hitB    = (q_rb == stRc) && stLive;

    // hold must suppress the write in the same cycle it rises, so the enable
    // is decoded from state and hold rather than registered.
    assign RegWrite = (state == WRITE) && !hold && stLive;
    assign rc       = stRc;
    assign wdata    = stData;

    assign stall    = stValid && (hitA || hitB);
    assign fwd_a    = (state == WRITE) && hitA;
    assign fwd_b    = (state == WRITE) && hitB;
    assign fwd_data = stData;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
// Directed bench for regfile_wr_arbiter. The stimulus process queues the
// expected grants and register writes; a monitor on the falling edge pops
// and compares whenever the DUT asserts a ready or RegWrite, and keeps a
// small register-file model fed from the write port.
// ----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [4:0]  req0_rc;
    logic [31:0] req0_wdata;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_rc;
    logic [31:0] req1_wdata;
    logic        req1_ready;
    logic        hold;
    logic        RegWrite;
    logic [4:0]  rc;
    logic [31:0] wdata;
    logic [4:0]  q_ra;
    logic [4:0]  q_rb;
    logic        stall;
    logic        fwd_a;
    logic        fwd_b;
    logic [31:0] fwd_data;

    regfile_wr_arbiter #(.ZERO_REG(5'd31)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_rc    (req0_rc),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rc    (req1_rc),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .hold       (hold),
        .RegWrite   (RegWrite),
        .rc         (rc),
        .wdata      (wdata),
        .q_ra       (q_ra),
        .q_rb       (q_rb),
        .stall      (stall),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .fwd_data   (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rc;
        logic [31:0] data;
    } wr_t;

    int          tests = 0;
    int          fails = 0;
    int          expGrant[$];
    wr_t         expWr[$];
    wr_t         monE;
    int          monG;
    logic [31:0] regs [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got %h expected nothing", name, act);
    endtask

    task automatic expectWr(input logic [4:0] r, input logic [31:0] d);
        wr_t e;
        e.rc   = r;
        e.data = d;
        expWr.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: writes and grants are checked against the queues in order.
    always @(negedge clk) begin
        if (RegWrite) begin
            regs[rc] = wdata;
            if (expWr.size() == 0) begin
                flag("unexpected_write", {27'b0, rc});
            end else begin
                monE = expWr.pop_front();
                check("wr_rc", 32'(rc), 32'(monE.rc));
                check("wr_data", wdata, monE.data);
            end
        end
        if (rst_n && (req0_ready || req1_ready)) begin
            check("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
            if (expGrant.size() == 0) begin
                flag("unexpected_grant", 32'(req1_ready));
            end else begin
                monG = expGrant.pop_front();
                check("grant", 32'(req1_ready), 32'(monG));
            end
        end
    end

    initial begin
        foreach (regs[i]) regs[i] = '0;
        rst_n = 1'b0; hold = 1'b0;
        req0_valid = 1'b0; req0_rc = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_rc = '0; req1_wdata = '0;
        q_ra = '0; q_rb = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_RegWrite", 32'(RegWrite), 32'd0);
        check("rst_rc", 32'(rc), 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_fwd_a", 32'(fwd_a), 32'd0);
        check("rst_fwd_b", 32'(fwd_b), 32'd0);

        // Single write r3
        cyc();
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_rc = 5'd3; req0_wdata = 32'hDEADBEEF;
        expGrant.push_back(0); expectWr(5'd3, 32'hDEADBEEF);
        @(negedge clk);
        check("s1_ready0", 32'(req0_ready), 32'd1);
        check("s1_first_cycle_nowrite", 32'(RegWrite), 32'd0);
        cyc();
        req0_valid = 1'b0;
        @(negedge clk);
        check("s1_RegWrite", 32'(RegWrite), 32'd1);
        check("s1_rc", 32'(rc), 32'd3);
        cyc();
        @(negedge clk);
        check("s1_r3", regs[3], 32'hDEADBEEF);

        // ZERO_REG write from requester 1
        cyc();
        req1_valid = 1'b1; req1_rc = 5'd31; req1_wdata = 32'h12345678;
        expGrant.push_back(1);
        @(negedge clk);
        check("zr_ready1", 32'(req1_ready), 32'd1);
        cyc();
        req1_valid = 1'b0; q_ra = 5'd31;
        @(negedge clk);
        check("zr_RegWrite", 32'(RegWrite), 32'd0);
        check("zr_stall", 32'(stall), 32'd0);
        cyc();
        q_ra = '0;
        @(negedge clk);
        check("zr_r31", regs[31], 32'd0);

        // Both valid: grants 0,1,0,1 with back-to-back writes
        cyc();
        req0_valid = 1'b1; req0_rc = 5'd1; req0_wdata = 32'h11111111;
        req1_valid = 1'b1; req1_rc = 5'd2; req1_wdata = 32'h22222222;
        for (int i = 0; i < 4; i++) begin
            expGrant.push_back(i % 2);
            if (i % 2 == 0) expectWr(5'd1, 32'h11111111);
            else            expectWr(5'd2, 32'h22222222);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) check("rr_b2b_write", 32'(RegWrite), 32'd1);
            cyc();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check("rr_last_rc", 32'(rc), 32'd2);
        cyc();
        @(negedge clk);
        check("rr_idle_nowrite", 32'(RegWrite), 32'd0);
        check("rr_r1", regs[1], 32'h11111111);
        check("rr_r2", regs[2], 32'h22222222);

        // Same rc from both: round-robin order, later write wins
        cyc();
        req0_valid = 1'b1; req0_rc = 5'd4; req0_wdata = 32'hAAAA0000;
        req1_valid = 1'b1; req1_rc = 5'd4; req1_wdata = 32'hBBBB1111;
        expGrant.push_back(0); expGrant.push_back(1);
        expectWr(5'd4, 32'hAAAA0000); expectWr(5'd4, 32'hBBBB1111);
        @(negedge clk);
        cyc();
        req0_valid = 1'b0;
        @(negedge clk);
        cyc();
        req1_valid = 1'b0;
        @(negedge clk);
        cyc();
        @(negedge clk);
        check("same_rc_r4", regs[4], 32'hBBBB1111);

        // Hold for three cycles after a write to r7
        cyc();
        req0_valid = 1'b1; req0_rc = 5'd7; req0_wdata = 32'h77777777;
        expGrant.push_back(0); expectWr(5'd7, 32'h77777777);
        @(negedge clk);
        cyc();
        req0_valid = 1'b0; hold = 1'b1; q_ra = 5'd7;
        @(negedge clk);
        check("hold1_RegWrite", 32'(RegWrite), 32'd0);
        check("hold1_stall", 32'(stall), 32'd1);
        for (int i = 0; i < 2; i++) begin
            cyc();
            req1_valid = 1'b1; req1_rc = 5'd8; req1_wdata = 32'h88888888;
            @(negedge clk);
            check("hold_RegWrite", 32'(RegWrite), 32'd0);
            check("hold_stall", 32'(stall), 32'd1);
            check("hold_ready1", 32'(req1_ready), 32'd0);
            check("hold_fwd_a", 32'(fwd_a), 32'd0);
        end
        cyc();
        hold = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check("unhold_in_HOLD_RegWrite", 32'(RegWrite), 32'd0);
        cyc();
        @(negedge clk);
        check("unhold_RegWrite", 32'(RegWrite), 32'd1);
        check("unhold_rc", 32'(rc), 32'd7);
        cyc();
        q_ra = '0;

        // Forwarding from the staged write to r5
        req0_valid = 1'b1; req0_rc = 5'd5; req0_wdata = 32'hA5A5A5A5;
        expGrant.push_back(0); expectWr(5'd5, 32'hA5A5A5A5);
        @(negedge clk);
        cyc();
        req0_valid = 1'b0; q_ra = 5'd6; q_rb = 5'd5;
        @(negedge clk);
        check("fwd_b", 32'(fwd_b), 32'd1);
        check("fwd_data", fwd_data, 32'hA5A5A5A5);
        check("fwd_stall", 32'(stall), 32'd1);
        check("fwd_a", 32'(fwd_a), 32'd0);
        cyc();
        @(negedge clk);
        check("fwd_idle_fwd_b", 32'(fwd_b), 32'd0);
        check("fwd_idle_stall", 32'(stall), 32'd0);

        // Reset while r9 is staged: the write is dropped
        cyc();
        q_ra = 5'd9; q_rb = '0;
        req0_valid = 1'b1; req0_rc = 5'd9; req0_wdata = 32'h99999999;
        expGrant.push_back(0);
        @(negedge clk);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_RegWrite", 32'(RegWrite), 32'd0);
        check("mid_rst_rc", 32'(rc), 32'd0);
        check("mid_rst_wdata", wdata, 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_fwd_a", 32'(fwd_a), 32'd0);
        check("mid_rst_fwd_b", 32'(fwd_b), 32'd0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_nowrite", 32'(RegWrite), 32'd0);
        cyc();
        @(negedge clk);
        check("post_rst_r9", regs[9], 32'd0);

        // After reset requester 0 wins the first contention again
        cyc();
        req0_valid = 1'b1; req0_rc = 5'd10; req0_wdata = 32'h0000000A;
        req1_valid = 1'b1; req1_rc = 5'd11; req1_wdata = 32'h0000000B;
        expGrant.push_back(0); expectWr(5'd10, 32'h0000000A);
        @(negedge clk);
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        repeat (2) cyc();

        check("grant_queue_drained", 32'(expGrant.size()), 32'd0);
        check("write_queue_drained", 32'(expWr.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
